// File: rtl/param_def_gap_accum.sv
// ---------------------------------------------------------------------------
// param_def_gap_accum
// Shared parameter definitions for the global-average-pool accumulator.
// Holds the default pixel width, channel count and frame size, the derived
// accumulator and counter widths, the FSM state type and the small width
// helpers used by the top and the accumulator RAM.
// No ports (package).
// ---------------------------------------------------------------------------
package param_def_gap_accum;

    // Pixel width, signed two's-complement fixed point.
    localparam int DEF_DATA_WIDTH  = 16;
    // Channels per pixel, legal range 2..1024.
    localparam int DEF_CHANNEL_NUM = 256;
    // Pixels per frame, power of two and at least 2.
    localparam int DEF_IMAGE_SIZE  = 1024;

    // Width needed to hold a counter that runs 0..n-1 (never below 1 bit).
    function automatic int calcCntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A full frame of one channel summed without loss: the pixel width plus
    // one bit per doubling of the frame size.
    function automatic int calcAccWidth(input int dataWidth, input int imageSize);
        return dataWidth + $clog2(imageSize);
    endfunction

    localparam int DEF_ACC_WIDTH    = calcAccWidth(DEF_DATA_WIDTH, DEF_IMAGE_SIZE);
    localparam int DEF_CH_CNT_WIDTH = calcCntWidth(DEF_CHANNEL_NUM);
    localparam int DEF_PX_CNT_WIDTH = calcCntWidth(DEF_IMAGE_SIZE);

    // Which pixel of the frame the incoming beat belongs to.
    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_LAST  = 2'd2
    } gapState_t;

endpackage

// File: rtl/gap_acc_ram.sv
// ---------------------------------------------------------------------------
// gap_acc_ram
// Simple dual-port accumulator storage, one word per channel, with a
// one-cycle synchronous read. Contents are never reset: every frame starts
// by overwriting each word, so stale data is harmless.
// Ports:
//   i_clk      clock, rising edge
//   i_wrEn     write enable
//   i_wrAddr   write address (channel)
//   i_wrData   write data
//   i_rdEn     read enable
//   i_rdAddr   read address (channel)
//   o_rdData   read data, valid the cycle after i_rdEn
// ---------------------------------------------------------------------------
module gap_acc_ram
    import param_def_gap_accum::*;
#(
    parameter int DEPTH = DEF_CHANNEL_NUM,
    parameter int WIDTH = DEF_ACC_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_wrEn,
    input  logic [calcCntWidth(DEPTH)-1:0]  i_wrAddr,
    input  logic [WIDTH-1:0]                i_wrData,
    input  logic                            i_rdEn,
    input  logic [calcCntWidth(DEPTH)-1:0]  i_rdAddr,
    output logic [WIDTH-1:0]                o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Read port; a same-cycle write to the same word is resolved by the
    // caller, so this port simply returns the stored word.
    always_ff @(posedge i_clk) begin
        if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/cnn_gap_accum_top.sv
// ---------------------------------------------------------------------------
// cnn_gap_accum_top
// Global average pool over a channel-fastest raster stream. Each channel's
// pixels are summed across the frame in an accumulator RAM; on the last
// pixel the rounded average is emitted, one output per channel per frame.
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset (deassertion synchronised here)
//   valid_in    qualifies pxl_in, no backpressure
//   pxl_in      input pixel, signed
//   pxl_out     per-channel frame average, holds when valid_out is low
//   valid_out   qualifies pxl_out, two cycles after the last-pixel beat
//   frame_done  pulse with the last valid_out of a frame
// ---------------------------------------------------------------------------
module cnn_gap_accum_top
    import param_def_gap_accum::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
    parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int ACC_WIDTH = calcAccWidth(DATA_WIDTH, IMAGE_SIZE);
    localparam int CH_W      = calcCntWidth(CHANNEL_NUM);
    localparam int PX_W      = calcCntWidth(IMAGE_SIZE);
    localparam int SHIFT     = $clog2(IMAGE_SIZE);

    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CHANNEL_NUM - 1);
    localparam logic [PX_W-1:0] PX_PENULT = PX_W'(IMAGE_SIZE - 2);

    logic [1:0]            r_rstSync;
    logic                  w_rstN;

    logic [CH_W-1:0]       r_chCnt;
    logic [PX_W-1:0]       r_pxCnt;
    gapState_t             r_state;
    logic                  w_chWrap;

    logic                  r_s1Valid;
    logic [CH_W-1:0]       r_s1Ch;
    gapState_t             r_s1State;
    logic [DATA_WIDTH-1:0] r_s1Data;
    logic                  r_fwdHit;
    logic [ACC_WIDTH-1:0]  r_fwdData;

    logic [ACC_WIDTH-1:0]  w_ramRdData;
    logic [ACC_WIDTH-1:0]  w_dataExt;
    logic [ACC_WIDTH-1:0]  w_accRd;
    logic [ACC_WIDTH-1:0]  w_accSum;
    logic                  w_wrEn;
    logic [CH_W-1:0]       w_wrAddr;
    logic [ACC_WIDTH-1:0]  w_wrData;
    logic signed [ACC_WIDTH:0] w_roundSum;
    logic [DATA_WIDTH-1:0] w_avg;
    logic                  w_emit;

    // Reset asserts immediately but is released only after two clean clock
    // edges, so every flop below leaves reset in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    assign w_chWrap = (r_chCnt == CH_LAST);

    // Channel/pixel counters and the frame-position FSM. Only valid beats
    // move anything, so input gaps of any length are transparent.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_chCnt <= '0;
            r_pxCnt <= '0;
            r_state <= ST_FIRST;
        end else if (valid_in) begin
            if (w_chWrap) begin
                r_chCnt <= '0;
                case (r_state)
                    ST_FIRST: begin
                        r_pxCnt <= r_pxCnt + PX_W'(1);
                        r_state <= (IMAGE_SIZE == 2) ? ST_LAST : ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        r_pxCnt <= r_pxCnt + PX_W'(1);
                        if (r_pxCnt == PX_PENULT) begin
                            r_state <= ST_LAST;
                        end
                    end
                    default: begin
                        r_pxCnt <= '0;
                        r_state <= ST_FIRST;
                    end
                endcase
            end else begin
                r_chCnt <= r_chCnt + CH_W'(1);
            end
        end
    end

    // Stage 1: capture the beat alongside the RAM read of its channel. If
    // stage 2 is writing the very word being read this cycle, the write
    // value is captured instead of the stale RAM word.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_s1Valid <= 1'b0;
            r_s1Ch    <= '0;
            r_s1State <= ST_FIRST;
            r_s1Data  <= '0;
            r_fwdHit  <= 1'b0;
            r_fwdData <= '0;
        end else begin
            r_s1Valid <= valid_in;
            r_fwdHit  <= valid_in && w_wrEn && (w_wrAddr == r_chCnt);
            r_fwdData <= w_wrData;
            if (valid_in) begin
                r_s1Ch    <= r_chCnt;
                r_s1State <= r_state;
                r_s1Data  <= pxl_in;
            end
        end
    end

    gap_acc_ram #(
        .DEPTH (CHANNEL_NUM),
        .WIDTH (ACC_WIDTH)
    ) u_accRam (
        .i_clk    (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (w_wrAddr),
        .i_wrData (w_wrData),
        .i_rdEn   (valid_in),
        .i_rdAddr (r_chCnt),
        .o_rdData (w_ramRdData)
    );

    // Stage 2 datapath. The first pixel overwrites the word, so the RAM
    // never needs clearing; the last pixel only feeds the averager.
    assign w_dataExt = {{(ACC_WIDTH - DATA_WIDTH){r_s1Data[DATA_WIDTH-1]}}, r_s1Data};
    assign w_accRd   = r_fwdHit ? r_fwdData : w_ramRdData;
    assign w_accSum  = w_accRd + w_dataExt;
    assign w_wrEn    = r_s1Valid && (r_s1State != ST_LAST);
    assign w_wrAddr  = r_s1Ch;
    assign w_wrData  = (r_s1State == ST_FIRST) ? w_dataExt : w_accSum;
    assign w_emit    = r_s1Valid && (r_s1State == ST_LAST);

    // Round half up, then an arithmetic shift divides by the frame size.
    // One guard bit keeps the rounding offset from wrapping the sum.
    assign w_roundSum = $signed({w_accSum[ACC_WIDTH-1], w_accSum})
                      + $signed((ACC_WIDTH + 1)'(IMAGE_SIZE / 2));
    assign w_avg      = DATA_WIDTH'(w_roundSum >>> SHIFT);

    // Registered outputs; pxl_out keeps the previous average between
    // outputs.
    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            pxl_out    <= '0;
        end else begin
            valid_out  <= w_emit;
            frame_done <= w_emit && (r_s1Ch == CH_LAST);
            if (w_emit) begin
                pxl_out <= w_avg;
            end
        end
    end

endmodule

// File: tb/tb_cnn_gap_accum_top.sv
// ---------------------------------------------------------------------------
// tb_cnn_gap_accum_top
// Two instances share one input bus: dutA (4 channels, 4 pixels per frame)
// and dutB (4 channels, 2 pixels per frame, the first-to-last corner).
// Expected averages come from a floor-division model over the whole frame.
// ---------------------------------------------------------------------------
module tb_cnn_gap_accum_top;

    localparam int DW     = 16;
    localparam int CH     = 4;
    localparam int NPIX_A = 4;
    localparam int NPIX_B = 2;

    typedef struct {
        logic [DW-1:0] value;
        logic          done;
        int            cycle;
    } expBeat_t;

    logic          clk = 1'b0;
    logic          resetN;
    logic          vIn;
    int            sel;
    logic [DW-1:0] pxlIn;
    logic          validInA, validInB;
    logic [DW-1:0] pxlOutA, pxlOutB;
    logic          validOutA, validOutB;
    logic          frameDoneA, frameDoneB;

    int            total = 0;
    int            bad = 0;
    int            cycleCnt = 0;
    bit            monOn = 1'b0;
    logic [DW-1:0] lastOutA = '0;
    logic [DW-1:0] lastOutB = '0;
    expBeat_t      expA[$];
    expBeat_t      expB[$];
    logic signed [DW-1:0] frame [NPIX_A][CH];

    assign validInA = vIn && (sel == 0);
    assign validInB = vIn && (sel == 1);

    cnn_gap_accum_top #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .IMAGE_SIZE(NPIX_A)) dutA (
        .clk        (clk),
        .reset      (resetN),
        .valid_in   (validInA),
        .pxl_in     (pxlIn),
        .pxl_out    (pxlOutA),
        .valid_out  (validOutA),
        .frame_done (frameDoneA)
    );

    cnn_gap_accum_top #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .IMAGE_SIZE(NPIX_B)) dutB (
        .clk        (clk),
        .reset      (resetN),
        .valid_in   (validInB),
        .pxl_in     (pxlIn),
        .pxl_out    (pxlOutB),
        .valid_out  (validOutB),
        .frame_done (frameDoneB)
    );

    // Free-running clock and a cycle count used to check output latency.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCnt++;
    end

    // Safety net so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d required completion", cycleCnt);
        $fatal(1, "[TB] watchdog");
    end

    // Reference average: frame sum plus half the frame size, floor-divided
    // by the frame size.
    function automatic logic [DW-1:0] refAvg(input int nPix, input int ch);
        longint sum;
        longint s;
        sum = 0;
        for (int p = 0; p < nPix; p++) begin
            sum += longint'(frame[p][ch]);
        end
        s = sum + longint'(nPix / 2);
        if (s >= 0) begin
            return DW'(s / nPix);
        end
        return DW'(-((-s + nPix - 1) / nPix));
    endfunction

    // Sends the current frame to one instance, with a chosen percentage of
    // idle cycles before each beat. maxBeats cuts the frame short. Last-pixel
    // beats queue their expected average and arrival cycle.
    task automatic applyStimulus(input int dut, input int idlePct, input int maxBeats);
        int nPix;
        int beats;
        expBeat_t e;
        nPix = (dut == 0) ? NPIX_A : NPIX_B;
        beats = 0;
        for (int p = 0; p < nPix; p++) begin
            for (int c = 0; c < CH; c++) begin
                if (beats == maxBeats) begin
                    vIn = 1'b0;
                    return;
                end
                while (int'($urandom_range(99)) < idlePct) begin
                    vIn = 1'b0;
                    @(posedge clk);
                    #1;
                end
                sel   = dut;
                vIn   = 1'b1;
                pxlIn = frame[p][c];
                if (p == nPix - 1) begin
                    e.value = refAvg(nPix, c);
                    e.done  = (c == CH - 1);
                    e.cycle = cycleCnt + 2;
                    if (dut == 0) expA.push_back(e);
                    else          expB.push_back(e);
                end
                @(posedge clk);
                #1;
                beats++;
            end
        end
        vIn = 1'b0;
    endtask

    // Compares one instance's outputs for the current cycle: a valid output
    // must match the next queued average, its frame_done flag and its cycle;
    // otherwise frame_done stays low and pxl_out holds.
    task automatic checkOutput(input int dut, input logic vo, input logic fd, input logic [DW-1:0] po);
        expBeat_t e;
        logic [DW-1:0] held;
        int pending;
        held    = (dut == 0) ? lastOutA : lastOutB;
        pending = (dut == 0) ? expA.size() : expB.size();
        if (vo === 1'b1) begin
            total++;
            assert (pending != 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_valid dut%0d got pxl_out=%0d required no output", dut, $signed(po));
            end
            if (pending != 0) begin
                if (dut == 0) e = expA.pop_front();
                else          e = expB.pop_front();
                total++;
                assert (po === e.value) else begin
                    bad++;
                    $error("[TB] FAIL avg dut%0d got %0d expected %0d", dut, $signed(po), $signed(e.value));
                end
                total++;
                assert (fd === e.done) else begin
                    bad++;
                    $error("[TB] FAIL frame_done dut%0d got %b expected %b", dut, fd, e.done);
                end
                total++;
                assert (cycleCnt === e.cycle) else begin
                    bad++;
                    $error("[TB] FAIL latency dut%0d got cycle %0d expected %0d", dut, cycleCnt, e.cycle);
                end
            end
            if (dut == 0) lastOutA = po;
            else          lastOutB = po;
        end else begin
            total++;
            assert (fd === 1'b0) else begin
                bad++;
                $error("[TB] FAIL idle_frame_done dut%0d got %b expected 0", dut, fd);
            end
            total++;
            assert (po === held) else begin
                bad++;
                $error("[TB] FAIL hold dut%0d got %0d expected %0d", dut, $signed(po), $signed(held));
            end
        end
    endtask

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (monOn) begin
            if (resetN !== 1'b1) begin
                lastOutA = '0;
                lastOutB = '0;
            end
            checkOutput(0, validOutA, frameDoneA, pxlOutA);
            checkOutput(1, validOutB, frameDoneB, pxlOutB);
        end
    end

    // Waits (bounded) for every queued average to appear.
    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((expA.size() != 0 || expB.size() != 0) && waited < 64) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        total++;
        assert (expA.size() == 0 && expB.size() == 0) else begin
            bad++;
            $error("[TB] FAIL drain got %0d/%0d pending outputs expected 0/0", expA.size(), expB.size());
        end
    endtask

    // Reset-state check on dutA and dutB.
    task automatic checkResetState(input string tag);
        total++;
        assert (validOutA === 1'b0 && validOutB === 1'b0) else begin
            bad++;
            $error("[TB] FAIL %s valid_out got %b/%b expected 0/0", tag, validOutA, validOutB);
        end
        total++;
        assert (frameDoneA === 1'b0 && frameDoneB === 1'b0) else begin
            bad++;
            $error("[TB] FAIL %s frame_done got %b/%b expected 0/0", tag, frameDoneA, frameDoneB);
        end
        total++;
        assert (pxlOutA === '0 && pxlOutB === '0) else begin
            bad++;
            $error("[TB] FAIL %s pxl_out got %0d/%0d expected 0/0", tag, $signed(pxlOutA), $signed(pxlOutB));
        end
    endtask

    task automatic fillRandom();
        for (int p = 0; p < NPIX_A; p++) begin
            for (int c = 0; c < CH; c++) begin
                frame[p][c] = DW'($urandom);
            end
        end
    endtask

    task automatic releaseReset();
        resetN = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        vIn    = 1'b0;
        sel    = 0;
        pxlIn  = '0;
        resetN = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        monOn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        releaseReset();

        $display("[TB] constant input 5");
        for (int p = 0; p < NPIX_A; p++)
            for (int c = 0; c < CH; c++) frame[p][c] = 16'sd5;
        applyStimulus(0, 0, 1000);
        waitDrain();

        $display("[TB] channel-distinct input");
        for (int p = 0; p < NPIX_A; p++)
            for (int c = 0; c < CH; c++) frame[p][c] = DW'(c * 10 - 15);
        applyStimulus(0, 0, 1000);
        waitDrain();

        $display("[TB] rounding and full scale");
        for (int p = 0; p < NPIX_A; p++) begin
            frame[p][0] = (p < 3) ? 16'sd1 : 16'sd0;
            frame[p][1] = (p < 2) ? -16'sd1 : 16'sd0;
            frame[p][2] = 16'sh7fff;
            frame[p][3] = 16'sh8000;
        end
        applyStimulus(0, 0, 1000);
        waitDrain();

        $display("[TB] random frame gap-free, then gapped, then back-to-back");
        fillRandom();
        applyStimulus(0, 0, 1000);
        applyStimulus(0, 30, 1000);
        fillRandom();
        applyStimulus(0, 30, 1000);
        fillRandom();
        applyStimulus(0, 0, 1000);
        waitDrain();

        $display("[TB] two-pixel frames on dutB");
        for (int f = 0; f < 4; f++) begin
            fillRandom();
            applyStimulus(1, (f < 2) ? 0 : 30, 1000);
        end
        waitDrain();

        $display("[TB] reset in pixel 2, then fresh frame");
        fillRandom();
        applyStimulus(0, 0, 2 * CH + 2);
        resetN = 1'b0;
        #1;
        checkResetState("midreset_async");
        repeat (3) @(posedge clk);
        #1;
        checkResetState("midreset_hold");
        releaseReset();
        fillRandom();
        applyStimulus(0, 30, 1000);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
